pico_ctrl: RTL

//  picoMIPS control sequencer; sits directly upstream of the program counter and drives
//  its PCincr/PCabsbranch/PCrelbranch inputs. Decodes the opcode of the current

---
 rtl/pico_pkg.sv | 21 ++
 rtl/pico_ctrl.sv | 105 ++++++++++
 2 files changed

// File: rtl/pico_pkg.sv
// pico_pkg: opcode/state types and constants for the picoMIPS control sequencer (HALT state under PICO_CTRL_HALT_EN)
package pico_pkg;
  localparam int OPSIZE = 3;
  localparam int ISIZE = 8;
  localparam logic [ISIZE-1:0] HALT_IMM = '1;
  typedef enum logic [OPSIZE-1:0] {
    NOP    = 3'd0,
    ADD    = 3'd1,
    ADDI   = 3'd2,
    MUL    = 3'd3,
    BEQ    = 3'd4,
    BNE    = 3'd5,
    JMP    = 3'd6,
    WAITIN = 3'd7
  } opcode_t;
`ifdef PICO_CTRL_HALT_EN
  typedef enum logic [1:0] {RUN, WAIT_IN, HALT} ctrl_state_t;
`else
  typedef enum logic [1:0] {RUN, WAIT_IN} ctrl_state_t;
`endif
endpackage

// File: rtl/pico_ctrl.sv
// pico_ctrl: picoMIPS control sequencer driving PC, register write and input handshake (HALT via PICO_CTRL_HALT_EN)
module pico_ctrl
  import pico_pkg::*;
#(
  parameter int OPsize = 3,
  parameter int Isize  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [OPsize-1:0] opcode,
  input  logic [Isize-1:0]  imm,
  input  logic              alu_z,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              PCincr,
  output logic              PCabsbranch,
  output logic              PCrelbranch,
  output logic              w_en,
  output logic              wsel_in,
  output logic              halted
);
  ctrl_state_t state, state_nxt;
  logic z_q, z_nxt;
  logic rdy, incr, absb, relb, we, wsel, hlt;
  opcode_t op;
  assign op = opcode_t'(opcode);
`ifndef PICO_CTRL_HALT_EN
  logic unused_imm;
  assign unused_imm = ^imm;
`endif
  // state and registered zero flag
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= RUN;
      z_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      z_q   <= z_nxt;
    end
  // opcode decode and next-state selection
  always_comb begin
    state_nxt = state;
    z_nxt = z_q;
    rdy = 1'b0;
    incr = 1'b0;
    absb = 1'b0;
    relb = 1'b0;
    we = 1'b0;
    wsel = 1'b0;
    hlt = 1'b0;
    case (state)
      RUN:
        case (op)
          NOP: begin
`ifdef PICO_CTRL_HALT_EN
            if (&imm) state_nxt = HALT;
            else incr = 1'b1;
`else
            incr = 1'b1;
`endif
          end
          ADD, ADDI, MUL: begin
            incr = 1'b1;
            we = 1'b1;
            z_nxt = alu_z;
          end
          BEQ: begin
            relb = z_q;
            incr = !z_q;
          end
          BNE: begin
            relb = !z_q;
            incr = z_q;
          end
          JMP: absb = 1'b1;
          default: begin
            rdy = 1'b1;
            we = in_valid;
            wsel = in_valid;
            incr = in_valid;
            state_nxt = in_valid ? RUN : WAIT_IN;
          end
        endcase
      WAIT_IN: begin
        rdy = 1'b1;
        we = in_valid;
        wsel = in_valid;
        incr = in_valid;
        state_nxt = in_valid ? RUN : WAIT_IN;
      end
`ifdef PICO_CTRL_HALT_EN
      HALT: hlt = 1'b1;
`endif
      default: state_nxt = RUN;
    endcase
  end
  // every output forced low while reset is held
  assign in_ready    = rdy & ~reset;
  assign PCincr      = incr & ~reset;
  assign PCabsbranch = absb & ~reset;
  assign PCrelbranch = relb & ~reset;
  assign w_en        = we & ~reset;
  assign wsel_in     = wsel & ~reset;
  assign halted      = hlt & ~reset;
endmodule
